// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: fetch-to-decode valid/ready bundle.
// The master drives the head of the prefetch queue and the slave accepts it.
interface instr_fetch_queue_if #(
   parameter int PROG_CTR_WID = 10,
   parameter int INSTR_WID    = 16
);
   logic                    out_valid;
   logic                    out_ready;
   logic [INSTR_WID-1:0]    out_instr;
   logic [PROG_CTR_WID-1:0] out_pc;

   modport master (
      output out_valid,
      output out_instr,
      output out_pc,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_instr,
      input  out_pc,
      output out_ready
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction store, fetch PC and prefetch queue.
// INSTR_MEM_LOAD_EN adds the program-load write port.
module instr_fetch_queue #(
  parameter int                      PROG_CTR_WID = 10,
  parameter int                      INSTR_WID    = 16,
  parameter int                      FIFO_DEPTH   = 4,
  parameter logic [PROG_CTR_WID-1:0] RESET_PC     = '0,
  parameter string                   INIT_FILE    = ""
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_en,
  input  logic                        redirect_valid,
  input  logic [PROG_CTR_WID-1:0]     redirect_pc,
  instr_fetch_queue_if.master         dq,
`ifdef INSTR_MEM_LOAD_EN
  input  logic                        load_we,
  input  logic [PROG_CTR_WID-1:0]     load_addr,
  input  logic [INSTR_WID-1:0]        load_data,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [INSTR_WID-1:0]    mem     [2**PROG_CTR_WID];
  logic [INSTR_WID-1:0]    instr_q [FIFO_DEPTH];
  logic [PROG_CTR_WID-1:0] pc_q    [FIFO_DEPTH];

  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [CW-1:0]           count;
  logic [PROG_CTR_WID-1:0] fetch_pc;

  logic                    ld;
  logic                    pop;
  logic                    full;
  logic                    fetch_ok;
  logic                    push;
  logic [PROG_CTR_WID-1:0] push_addr;
  logic [AW-1:0]           push_idx;

`ifdef INSTR_MEM_LOAD_EN
  assign ld = load_we;

  always_ff @(posedge clk) begin
    if (rst_n && load_we) mem[load_addr] <= load_data;
  end
`else
  assign ld = 1'b0;
`endif

  assign dq.out_valid = (count != '0);
  assign pop          = dq.out_valid & dq.out_ready;
  assign full         = (count == CW'(FIFO_DEPTH));
  assign fetch_ok     = fetch_en & ~ld;
  assign fifo_count   = count;

  always_comb begin
    push      = 1'b0;
    push_addr = fetch_pc;
    push_idx  = wr_ptr;
    if (redirect_valid) begin
      push      = fetch_ok;
      push_addr = redirect_pc;
      push_idx  = '0;
    end else begin
      push = fetch_ok & (~full | pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      rd_ptr   <= '0;
      wr_ptr   <= push ? AW'(1) : '0;
      count    <= push ? CW'(1) : '0;
      fetch_pc <= push ? redirect_pc + 1'b1 : redirect_pc;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      instr_q[push_idx] <= mem[push_addr];
      pc_q[push_idx]    <= push_addr;
    end
  end

  assign dq.out_instr = dq.out_valid ? instr_q[rd_ptr] : '0;
  assign dq.out_pc    = dq.out_valid ? pc_q[rd_ptr]    : '0;
endmodule
